// File: rtl/decoder_stage_controller_pkg.sv
// Shared decoder parameters: the stage codes broadcast to every PE and their width.
// Leaf PEs and the stage controller both import this so the encoding lives in one place.
package decoder_stage_controller_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef logic [STAGE_WIDTH-1:0] stage_t;

    localparam stage_t STAGE_IDLE                = 3'd0;
    localparam stage_t STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam stage_t STAGE_GROW                = 3'd2;
    localparam stage_t STAGE_MERGE               = 3'd3;
    localparam stage_t STAGE_PEELING             = 3'd4;

endpackage

// File: rtl/decoder_stage_controller_if.sv
// Controller <-> PE-array signals: round start and OR-reduced PE status in, stage broadcast and decode status out.
// The master modport is the controller side; the array top level uses the slave modport.
interface decoder_stage_controller_if;
    import decoder_stage_controller_pkg::*;

    logic        new_round_start;
    logic        busy_in;
    logic        odd_in;
    stage_t      global_stage;
    logic        result_valid;
    logic [7:0]  iteration_count;
    logic [15:0] cycle_count;
    logic        timeout;

    modport master (
        input  new_round_start, busy_in, odd_in,
        output global_stage, result_valid, iteration_count, cycle_count, timeout
    );

    modport slave (
        output new_round_start, busy_in, odd_in,
        input  global_stage, result_valid, iteration_count, cycle_count, timeout
    );

endinterface

// File: rtl/decoder_stage_controller.sv
// Sequences the PE array through load/grow/merge/peel; all outputs registered, one cycle after each decision.
// No backpressure: busy_in only holds MERGE/PEEL open once the settle window has elapsed.
module decoder_stage_controller
    import decoder_stage_controller_pkg::*;
#(
    parameter int GROW_CYCLES    = 2,
    parameter int SETTLE_CYCLES  = 3,
    parameter int MAX_ITERATIONS = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    decoder_stage_controller_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GROW,
        S_MERGE,
        S_PEEL,
        S_DONE
    } state_t;

    // One counter times both GROW and the settle window, so it must reach the larger of the two.
    localparam int DWELL_MAX = (GROW_CYCLES > SETTLE_CYCLES) ? GROW_CYCLES : SETTLE_CYCLES;
    localparam int DWELL_W   = $clog2(DWELL_MAX + 1);

    state_t               state_q;
    state_t               state_d;
    logic [DWELL_W-1:0]   dwell_q;
    logic [7:0]           iter_q;
    logic [15:0]          cyc_q;
    logic                 timeout_q;
    stage_t               stage_q;
    logic                 valid_q;

    logic                 settled;
    logic                 grow_done;
    logic                 iter_at_max;
    logic                 set_timeout;

    function automatic stage_t stage_of(input state_t s);
        case (s)
            S_LOAD:  return STAGE_MEASUREMENT_LOADING;
            S_GROW:  return STAGE_GROW;
            S_MERGE: return STAGE_MERGE;
            S_PEEL:  return STAGE_PEELING;
            default: return STAGE_IDLE;
        endcase
    endfunction

    // dwell_q is 0 in the first cycle of a state; the current cycle counts toward the window.
    assign settled     = (int'(dwell_q) + 1) >= SETTLE_CYCLES;
    assign grow_done   = int'(dwell_q) == (GROW_CYCLES - 1);
    assign iter_at_max = int'(iter_q) >= MAX_ITERATIONS;

    always_comb begin
        state_d     = state_q;
        set_timeout = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.new_round_start) state_d = S_LOAD;
            S_LOAD:  state_d = S_MERGE;
            S_GROW:  if (grow_done) state_d = S_MERGE;
            S_MERGE: begin
                if (settled && !bus.busy_in) begin
                    if (bus.odd_in && !iter_at_max) begin
                        state_d = S_GROW;
                    end else begin
                        state_d     = S_PEEL;
                        set_timeout = bus.odd_in;
                    end
                end
            end
            S_PEEL:  if (settled && !bus.busy_in) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dwell_q   <= '0;
            iter_q    <= '0;
            cyc_q     <= '0;
            timeout_q <= 1'b0;
            stage_q   <= STAGE_IDLE;
            valid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_of(state_d);
            valid_q <= (state_d == S_DONE);

            if (state_d != state_q) begin
                dwell_q <= '0;
            end else if (int'(dwell_q) < DWELL_MAX) begin
                dwell_q <= dwell_q + 1'b1;
            end

            if (state_q == S_IDLE && state_d == S_LOAD) begin
                iter_q    <= '0;
                cyc_q     <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (state_q != S_IDLE && cyc_q != 16'hFFFF) begin
                    cyc_q <= cyc_q + 16'd1;
                end
                if (state_d == S_GROW && state_q != S_GROW && iter_q != 8'hFF) begin
                    iter_q <= iter_q + 8'd1;
                end
                if (set_timeout) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.global_stage    = stage_q;
    assign bus.result_valid    = valid_q;
    assign bus.iteration_count = iter_q;
    assign bus.cycle_count     = cyc_q;
    assign bus.timeout         = timeout_q;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Directed bench for the stage controller, MAX_ITERATIONS=3 so the timeout path is reachable.
// Inputs change and outputs are sampled on the falling edge.
module tb_decoder_stage_controller;
    import decoder_stage_controller_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    decoder_stage_controller_if sif ();

    decoder_stage_controller #(
        .GROW_CYCLES    (2),
        .SETTLE_CYCLES  (3),
        .MAX_ITERATIONS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_stage(input string tag, input stage_t st, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, " stage"}, 32'(sif.global_stage), 32'(st));
            chk({tag, " result_valid"}, 32'(sif.result_valid), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic expect_done(input string tag, input int cc);
        chk({tag, " done stage"}, 32'(sif.global_stage), 32'(STAGE_IDLE));
        chk({tag, " done result_valid"}, 32'(sif.result_valid), 32'd1);
        chk({tag, " done cycle_count"}, 32'(sif.cycle_count), 32'(cc - 1));
        @(negedge clk);
        chk({tag, " after result_valid"}, 32'(sif.result_valid), 32'd0);
        chk({tag, " after stage"}, 32'(sif.global_stage), 32'(STAGE_IDLE));
        chk({tag, " final cycle_count"}, 32'(sif.cycle_count), 32'(cc));
    endtask

    task automatic start_decode();
        sif.new_round_start = 1'b1;
        @(negedge clk);
        sif.new_round_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] busy_pat;
        checks               = 0;
        failures             = 0;
        reset                = 1'b1;
        sif.new_round_start  = 1'b0;
        sif.busy_in          = 1'b0;
        sif.odd_in           = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset stage", 32'(sif.global_stage), 32'(STAGE_IDLE));
        chk("reset result_valid", 32'(sif.result_valid), 32'd0);
        chk("reset iteration_count", 32'(sif.iteration_count), 32'd0);
        chk("reset cycle_count", 32'(sif.cycle_count), 32'd0);
        chk("reset timeout", 32'(sif.timeout), 32'd0);
        reset = 1'b0;
        expect_stage("idle", STAGE_IDLE, 2);

        // Zero-defect round
        start_decode();
        chk("zd load cycle_count", 32'(sif.cycle_count), 32'd0);
        expect_stage("zd load", STAGE_MEASUREMENT_LOADING, 1);
        expect_stage("zd merge", STAGE_MERGE, 3);
        expect_stage("zd peel", STAGE_PEELING, 3);
        expect_done("zd", 8);
        chk("zd iteration_count", 32'(sif.iteration_count), 32'd0);
        @(negedge clk);
        chk("zd cycle_count holds", 32'(sif.cycle_count), 32'd8);

        // Two growth rounds
        sif.odd_in = 1'b1;
        start_decode();
        expect_stage("g2 load", STAGE_MEASUREMENT_LOADING, 1);
        expect_stage("g2 merge0", STAGE_MERGE, 3);
        chk("g2 iter after grow1 entry", 32'(sif.iteration_count), 32'd1);
        expect_stage("g2 grow1", STAGE_GROW, 2);
        expect_stage("g2 merge1", STAGE_MERGE, 3);
        chk("g2 iter after grow2 entry", 32'(sif.iteration_count), 32'd2);
        expect_stage("g2 grow2", STAGE_GROW, 2);
        sif.odd_in = 1'b0;
        expect_stage("g2 merge2", STAGE_MERGE, 3);
        expect_stage("g2 peel", STAGE_PEELING, 3);
        expect_done("g2", 18);
        chk("g2 iteration_count", 32'(sif.iteration_count), 32'd2);
        chk("g2 timeout", 32'(sif.timeout), 32'd0);

        // Busy stretch with an early glitch low
        busy_pat = 7'b0111101;
        start_decode();
        expect_stage("busy load", STAGE_MEASUREMENT_LOADING, 1);
        for (int i = 0; i < 7; i++) begin
            sif.busy_in = busy_pat[i];
            chk("busy merge stage", 32'(sif.global_stage), 32'(STAGE_MERGE));
            @(negedge clk);
        end
        sif.busy_in = 1'b0;
        expect_stage("busy peel", STAGE_PEELING, 3);
        expect_done("busy", 12);

        // Timeout with odd stuck high
        sif.odd_in = 1'b1;
        start_decode();
        chk("to timeout cleared at start", 32'(sif.timeout), 32'd0);
        expect_stage("to load", STAGE_MEASUREMENT_LOADING, 1);
        for (int g = 1; g <= 3; g++) begin
            expect_stage("to merge", STAGE_MERGE, 3);
            chk("to iteration_count", 32'(sif.iteration_count), 32'(g));
            expect_stage("to grow", STAGE_GROW, 2);
        end
        expect_stage("to merge last", STAGE_MERGE, 3);
        chk("to timeout set", 32'(sif.timeout), 32'd1);
        expect_stage("to peel", STAGE_PEELING, 3);
        expect_done("to", 23);
        chk("to timeout sticky", 32'(sif.timeout), 32'd1);
        chk("to iteration_count final", 32'(sif.iteration_count), 32'd3);

        // Reset during second GROW
        start_decode();
        expect_stage("rst load", STAGE_MEASUREMENT_LOADING, 1);
        expect_stage("rst merge0", STAGE_MERGE, 3);
        expect_stage("rst grow1", STAGE_GROW, 2);
        expect_stage("rst merge1", STAGE_MERGE, 3);
        chk("rst in grow2", 32'(sif.global_stage), 32'(STAGE_GROW));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sif.odd_in = 1'b0;
        chk("rst stage", 32'(sif.global_stage), 32'(STAGE_IDLE));
        chk("rst iteration_count", 32'(sif.iteration_count), 32'd0);
        chk("rst cycle_count", 32'(sif.cycle_count), 32'd0);
        chk("rst timeout", 32'(sif.timeout), 32'd0);
        expect_stage("rst idle", STAGE_IDLE, 3);

        // Reset wins over a simultaneous start
        reset = 1'b1;
        sif.new_round_start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sif.new_round_start = 1'b0;
        expect_stage("rst prio", STAGE_IDLE, 2);

        start_decode();
        expect_stage("rst fresh load", STAGE_MEASUREMENT_LOADING, 1);
        expect_stage("rst fresh merge", STAGE_MERGE, 3);
        expect_stage("rst fresh peel", STAGE_PEELING, 3);
        expect_done("rst fresh", 8);
        chk("rst fresh iteration_count", 32'(sif.iteration_count), 32'd0);

        // Start pulse during PEEL is dropped
        start_decode();
        expect_stage("nrs load", STAGE_MEASUREMENT_LOADING, 1);
        expect_stage("nrs merge", STAGE_MERGE, 3);
        expect_stage("nrs peel0", STAGE_PEELING, 1);
        sif.new_round_start = 1'b1;
        expect_stage("nrs peel1", STAGE_PEELING, 1);
        sif.new_round_start = 1'b0;
        expect_stage("nrs peel2", STAGE_PEELING, 1);
        expect_done("nrs", 8);
        expect_stage("nrs idle", STAGE_IDLE, 3);
        chk("nrs cycle_count held", 32'(sif.cycle_count), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_stage_controller.md
DECODER_STAGE_CONTROLLER -- requirements
Module: decoder_stage_controller

Interface
REQ-001 SHALL have parameter GROW_CYCLES, default 2: cycles global_stage is held at STAGE_GROW per growth round.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 3: minimum dwell in MERGE or PEELING before busy_in is trusted; covers the PE stage register plus the busy register.
REQ-003 SHALL have parameter MAX_ITERATIONS, default 255: growth-round limit.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port new_round_start, input, 1: single-cycle pulse; the measurement bus is valid on the following cycle.
REQ-007 SHALL have port busy_in, input, 1: OR of all PE busy outputs.
REQ-008 SHALL have port odd_in, input, 1: OR of all PE odd outputs.
REQ-009 SHALL have port global_stage, output, STAGE_WIDTH: registered stage broadcast to every PE.
REQ-010 SHALL have port result_valid, output, 1: one-cycle pulse when peeling completes.
REQ-011 SHALL have port iteration_count, output, 8: number of completed growth rounds in the current decode.
REQ-012 SHALL have port cycle_count, output, 16: cycles elapsed since decode start.
REQ-013 SHALL have port timeout, output, 1: sticky flag set when MAX_ITERATIONS is reached.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, GROW, MERGE, PEEL, DONE.
REQ-015 SHALL drive global_stage from the state: IDLE->STAGE_IDLE, LOAD->STAGE_MEASUREMENT_LOADING, GROW->STAGE_GROW, MERGE->STAGE_MERGE, PEEL->STAGE_PEELING, DONE->STAGE_IDLE.
REQ-016 IDLE SHALL move to LOAD on the cycle after new_round_start=1. On that transition it clears iteration_count, cycle_count and timeout.
REQ-017 LOAD SHALL last exactly 1 cycle, then move to MERGE so that clusters with initial parity resolve before the first growth.
REQ-018 GROW SHALL last exactly GROW_CYCLES cycles, then move to MERGE. iteration_count increments by 1 on GROW entry and saturates at 255.
REQ-019 A dwell counter SHALL reset on every state entry and saturate at SETTLE_CYCLES.
REQ-020 MERGE SHALL exit only when dwell ≥ SETTLE_CYCLES and busy_in=0 in the same cycle.
REQ-021 On MERGE exit the FSM SHALL go to GROW if odd_in=1 and iteration_count<MAX_ITERATIONS.
REQ-022 On MERGE exit the FSM SHALL go to PEEL if odd_in=0.
REQ-023 On MERGE exit the FSM SHALL go to PEEL and set timeout if odd_in=1 and iteration_count=MAX_ITERATIONS.
REQ-024 PEEL SHALL exit to DONE only when dwell ≥ SETTLE_CYCLES and busy_in=0.
REQ-025 DONE SHALL last 1 cycle with result_valid=1, then return to IDLE.
REQ-026 result_valid SHALL be 1 only while in DONE.
REQ-027 cycle_count SHALL increment every cycle in LOAD through DONE inclusive, saturate at 0xFFFF, and hold its value in IDLE.
REQ-028 new_round_start SHALL be ignored in every state except IDLE; no queuing.
REQ-029 busy_in and odd_in SHALL be ignored before the settle window and in IDLE, LOAD, GROW and DONE.
REQ-030 A decode with no defects SHALL still traverse LOAD, MERGE, PEEL and DONE with iteration_count=0.

Reset
REQ-031 reset=1 SHALL force state IDLE, global_stage=STAGE_IDLE, result_valid=0, iteration_count=0, cycle_count=0, timeout=0 and dwell=0 on the next edge.
REQ-032 Reset mid-decode SHALL abort the decode with no result_valid pulse.
REQ-033 reset SHALL take priority over new_round_start in the same cycle.

Structure
REQ-034 Stage codes (STAGE_IDLE, STAGE_MEASUREMENT_LOADING, STAGE_GROW, STAGE_MERGE, STAGE_PEELING) and STAGE_WIDTH SHALL come from the shared parameters package and not be redefined locally.
REQ-035 The FSM state encoding SHALL be local to the module.
REQ-036 The design SHALL be a single module with no sub-modules; the busy and odd OR-reductions live in the array top level.

Verification
REQ-037 Zero-defect round: pulse new_round_start, hold busy_in=0 and odd_in=0. Required: global_stage sequence IDLE,LOAD,MERGE×3,PEEL×3,IDLE; result_valid pulses once; iteration_count=0; cycle_count=8.
REQ-038 Two growth rounds: odd_in=1 at the first two MERGE exits, 0 at the third. Required: GROW held 2 cycles each time, iteration_count=2, one result_valid pulse.
REQ-039 Busy stretch: busy_in=1 for 6 cycles of MERGE, then 0. Required: MERGE lasts 7 cycles; a busy_in=0 glitch at dwell=1 does not cause an exit.
REQ-040 Timeout: MAX_ITERATIONS=3 with odd_in stuck at 1. Required: exactly 3 GROW phases, then PEEL, timeout=1, result_valid pulses.
REQ-041 Reset during the second GROW: all outputs return to reset values next cycle, no result_valid, and a fresh new_round_start then decodes normally.
REQ-042 new_round_start pulsed during PEEL: ignored, exactly one result_valid pulse, controller returns to IDLE.
